// File: rtl/lp_laser_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lp_laser_pack_pkg
// Description : Shared constants and helpers for the laser sample packer.
//               Holds the default geometry (sample width, samples per word,
//               FIFO depth) and the widths derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
package lp_laser_pack_pkg;

  // Simulation clock-to-Q default. The synthesizable RTL carries no delays.
  localparam real TCQ_DEF        = 0.1;

  localparam int  DATA_WIDTH_DEF = 16;
  localparam int  PACK_NUM_DEF   = 4;
  localparam int  FIFO_DEPTH_DEF = 16;

  // Widths derived from the default geometry
  localparam int  PACK_W = DATA_WIDTH_DEF * PACK_NUM_DEF;
  localparam int  IDX_W  = $clog2(PACK_NUM_DEF);
  localparam int  CNT_W  = $clog2(FIFO_DEPTH_DEF) + 1;

  // Width of an index over n items, never below one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : lp_laser_pack_pkg
`default_nettype wire

// File: rtl/lp_laser_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pack_sync_fifo
// Description : Synchronous first-word-fall-through FIFO for packed words.
//               The head word is presented on dout whenever empty is low.
// Ports       : clk_i/rst_i  - clock, synchronous active-high reset
//               wr_en/din    - write strobe and data
//               rd_en        - pop the head word (ignored while empty)
//               dout         - head word (zero while empty)
//               empty/full   - status
//               count        - words held, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module pack_sync_fifo
  import lp_laser_pack_pkg::*;
#(
  parameter int WIDTH = PACK_W,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             wr_do;
  logic             rd_do;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // write that coincides with a read. An empty FIFO never pops.
  assign rd_do = rd_en & ~empty;
  assign wr_do = wr_en & (~full | rd_do);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_do) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_do) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_do, rd_do})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; dout is masked while empty so stale entries are
  // never visible.
  always_ff @(posedge clk_i) begin
    if (wr_do) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : pack_sync_fifo
`default_nettype wire

// File: rtl/lp_laser_pack.sv
`default_nettype none
// ============================================================================
// Module      : lp_laser_pack
// Description : Packs PACK_NUM consecutive filtered laser samples into one
//               wide word, buffers the words in a FWFT FIFO and presents them
//               on a valid/ready interface with flush and overflow reporting.
// Ports       : clk_i/rst_i       - clock, synchronous active-high reset
//               lp_laser_vld_i    - sample strobe
//               lp_laser_data_i   - filtered sample
//               frame_start_i     - drop partial word, realign, clear overflow
//               flush_i           - emit partial word, zero-padded
//               pack_vld_o/rdy_i  - packed word handshake
//               pack_data_o       - packed word, sample 0 in the low lane
//               overflow_o        - sticky word-dropped flag
//               fifo_cnt_o        - words held in the FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module lp_laser_pack
  import lp_laser_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_NUM   = PACK_NUM_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0]          lp_laser_data_i,
  input  logic                           frame_start_i,
  input  logic                           flush_i,
  output logic                           pack_vld_o,
  output logic [DATA_WIDTH*PACK_NUM-1:0] pack_data_o,
  input  logic                           pack_rdy_i,
  output logic                           overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_cnt_o
);

  localparam int PACK_WIDTH = DATA_WIDTH * PACK_NUM;
  localparam int IDX_WIDTH  = idx_width(PACK_NUM);

  logic [IDX_WIDTH-1:0]  idx_q,       idx_d;
  logic [PACK_WIDTH-1:0] acc_q,       acc_d;
  logic                  push_vld_q,  push_vld_d;
  logic [PACK_WIDTH-1:0] push_data_q, push_data_d;
  logic                  overflow_q,  overflow_d;

  logic [PACK_WIDTH-1:0] acc_ins;
  logic                  last_lane;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_pop;

  assign last_lane = (idx_q == IDX_WIDTH'(PACK_NUM - 1));

  // Accumulator with the incoming sample dropped into lane idx
  always_comb begin
    acc_ins = acc_q;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (lp_laser_vld_i && (idx_q == IDX_WIDTH'(i))) begin
        acc_ins[i*DATA_WIDTH +: DATA_WIDTH] = lp_laser_data_i;
      end
    end
  end

  // Packing control. The accumulator is cleared whenever a word leaves it,
  // which is what makes flushed words zero-padded in the unfilled lanes.
  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    push_vld_d  = 1'b0;
    push_data_d = push_data_q;
    if (frame_start_i) begin
      // Realign: the partial word is dropped (frame start beats flush) and
      // a coincident sample opens the new word in lane 0.
      acc_d = '0;
      idx_d = '0;
      if (lp_laser_vld_i) begin
        acc_d[DATA_WIDTH-1:0] = lp_laser_data_i;
        idx_d                 = IDX_WIDTH'(1);
      end
    end else if (lp_laser_vld_i && last_lane) begin
      // Word completes; a coincident flush has nothing left to emit
      push_vld_d  = 1'b1;
      push_data_d = acc_ins;
      acc_d       = '0;
      idx_d       = '0;
    end else if (lp_laser_vld_i && flush_i) begin
      // Sample goes in first, then the partial word is flushed
      push_vld_d  = 1'b1;
      push_data_d = acc_ins;
      acc_d       = '0;
      idx_d       = '0;
    end else if (lp_laser_vld_i) begin
      acc_d = acc_ins;
      idx_d = idx_q + IDX_WIDTH'(1);
    end else if (flush_i && (idx_q != '0)) begin
      push_vld_d  = 1'b1;
      push_data_d = acc_q;
      acc_d       = '0;
      idx_d       = '0;
    end
  end

  // Sticky overflow: a staged word reaches a full FIFO with no pop to make room
  always_comb begin
    overflow_d = overflow_q;
    if (frame_start_i) begin
      overflow_d = 1'b0;
    end else if (push_vld_q && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      acc_q       <= '0;
      push_vld_q  <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      push_vld_q  <= push_vld_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fifo_pop = pack_rdy_i & ~fifo_empty;

  pack_sync_fifo #(
    .WIDTH (PACK_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wr_en (push_vld_q),
    .din   (push_data_q),
    .rd_en (pack_rdy_i),
    .dout  (pack_data_o),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt_o)
  );

  assign pack_vld_o = ~fifo_empty;
  assign overflow_o = overflow_q;

endmodule : lp_laser_pack
`default_nettype wire

// File: tb/tb_lp_laser_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_lp_laser_pack
// Description : Directed self-checking bench for lp_laser_pack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lp_laser_pack;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [15:0] data;
  logic        frame_start;
  logic        flush;
  logic        pack_vld;
  logic [63:0] pack_data;
  logic        pack_rdy;
  logic        overflow;
  logic [4:0]  fifo_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  lp_laser_pack u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lp_laser_vld_i  (vld),
    .lp_laser_data_i (data),
    .frame_start_i   (frame_start),
    .flush_i         (flush),
    .pack_vld_o      (pack_vld),
    .pack_data_o     (pack_data),
    .pack_rdy_i      (pack_rdy),
    .overflow_o      (overflow),
    .fifo_cnt_o      (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    vld  = 1'b1;
    data = d;
    tick();
    vld  = 1'b0;
  endtask

  function automatic logic [63:0] word_of(input int w);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'(w * 16 + l);
    return r;
  endfunction

  task automatic send_word(input int w);
    for (int l = 0; l < 4; l++) send(16'(w * 16 + l));
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; data = '0; frame_start = 1'b0;
    flush = 1'b0; pack_rdy = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_vld",  {63'd0, pack_vld}, 64'd0);
    chk("rst_data", pack_data, 64'd0);
    chk("rst_ovf",  {63'd0, overflow}, 64'd0);
    chk("rst_cnt",  {59'd0, fifo_cnt}, 64'd0);

    // Basic packing and two-clock latency
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    chk("t1_vld_n", {63'd0, pack_vld}, 64'd0);
    tick();
    chk("t1_vld",   {63'd0, pack_vld}, 64'd1);
    chk("t1_data",  pack_data, 64'h0004_0003_0002_0001);
    tick();
    chk("t1_pulse", {63'd0, pack_vld}, 64'd0);
    chk("t1_ovf",   {63'd0, overflow}, 64'd0);

    // Flush of a partial word, then a flush with nothing pending
    send(16'hAAAA); send(16'hBBBB); send(16'hCCCC);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_vld_n", {63'd0, pack_vld}, 64'd0);
    tick();
    chk("t2_vld",   {63'd0, pack_vld}, 64'd1);
    chk("t2_data",  pack_data, 64'h0000_CCCC_BBBB_AAAA);
    tick();
    chk("t2_pulse", {63'd0, pack_vld}, 64'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    chk("t2_noflush_vld", {63'd0, pack_vld}, 64'd0);
    chk("t2_noflush_cnt", {59'd0, fifo_cnt}, 64'd0);

    // Flush together with the completing sample yields exactly one word
    send(16'h0011); send(16'h0022); send(16'h0033);
    flush = 1'b1; send(16'h0044); flush = 1'b0;
    tick();
    chk("t2b_data", pack_data, 64'h0044_0033_0022_0011);
    tick();
    chk("t2b_once", {63'd0, pack_vld}, 64'd0);
    tick(); tick();
    chk("t2b_once2", {63'd0, pack_vld}, 64'd0);

    // Overflow: 17 words with the consumer stalled
    pack_rdy = 1'b0;
    for (int w = 1; w <= 17; w++) send_word(w);
    tick(); tick();
    chk("t3_cnt", {59'd0, fifo_cnt}, 64'd16);
    chk("t3_ovf", {63'd0, overflow}, 64'd1);
    pack_rdy = 1'b1;
    for (int w = 1; w <= 16; w++) begin
      chk($sformatf("t3_drain_vld%0d", w), {63'd0, pack_vld}, 64'd1);
      chk($sformatf("t3_drain_dat%0d", w), pack_data, word_of(w));
      tick();
    end
    chk("t3_no17", {63'd0, pack_vld}, 64'd0);
    chk("t3_ovf_held", {63'd0, overflow}, 64'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t3_ovf_clr", {63'd0, overflow}, 64'd0);

    // Push and pop together on a full FIFO
    pack_rdy = 1'b0;
    for (int w = 32; w < 48; w++) send_word(w);
    send(16'(48 * 16 + 0)); send(16'(48 * 16 + 1)); send(16'(48 * 16 + 2));
    send(16'(48 * 16 + 3));
    chk("t4_full", {59'd0, fifo_cnt}, 64'd16);
    pack_rdy = 1'b1; tick(); pack_rdy = 1'b0;
    chk("t4_cnt", {59'd0, fifo_cnt}, 64'd16);
    chk("t4_ovf", {63'd0, overflow}, 64'd0);
    pack_rdy = 1'b1;
    for (int w = 33; w <= 48; w++) begin
      chk($sformatf("t4_drain_dat%0d", w), pack_data, word_of(w));
      tick();
    end
    chk("t4_empty", {59'd0, fifo_cnt}, 64'd0);

    // frame_start with a coincident sample realigns packing
    send(16'h1111); send(16'h2222);
    frame_start = 1'b1; send(16'h1234); frame_start = 1'b0;
    send(16'h2000); send(16'h3000); send(16'h4000);
    chk("t5_vld_n", {63'd0, pack_vld}, 64'd0);
    tick();
    chk("t5_vld",  {63'd0, pack_vld}, 64'd1);
    chk("t5_data", pack_data, 64'h4000_3000_2000_1234);
    tick();
    chk("t5_pulse", {63'd0, pack_vld}, 64'd0);

    // Reset mid-stream clears FIFO and partial word
    pack_rdy = 1'b0;
    send_word(5); send_word(6);
    send(16'h7777); send(16'h8888);
    tick(); tick();
    chk("t6_cnt_pre", {59'd0, fifo_cnt}, 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_vld",  {63'd0, pack_vld}, 64'd0);
    chk("t6_cnt",  {59'd0, fifo_cnt}, 64'd0);
    chk("t6_data", pack_data, 64'd0);
    pack_rdy = 1'b1;
    send(16'h0005); send(16'h0006); send(16'h0007); send(16'h0008);
    tick();
    chk("t6_word_vld", {63'd0, pack_vld}, 64'd1);
    chk("t6_word",     pack_data, 64'h0008_0007_0006_0005);
    tick();
    chk("t6_after", {63'd0, pack_vld}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_lp_laser_pack
`default_nettype wire
